// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 matrix keypad. Each column is driven low in turn while the
// pulled-up rows are sampled. After every full 16-key scan the snapshot is
// classified as no key, a single key k, or several keys. A classification
// must repeat on DEBOUNCE_SCANS consecutive scans before it is acted on.
// A committed single press produces one KEY_VALID pulse. A full release is
// needed before another press can be reported.
//
// Ports:
//   CLOCK_50   in   1  system clock (only clock)
//   RST_N      in   1  asynchronous reset, active low
//   COL        out  4  column drive, active low, one-cold
//   ROW        in   4  row sense, low = key closed in the driven column (async)
//   KEY_CODE   out  4  committed key index, row*4 + col
//   KEY_VALID  out  1  one-cycle pulse per newly committed press
//   KEY_HELD   out  1  high while a committed press is in effect
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    output logic [3:0] COL,
    input  logic [3:0] ROW,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } cls_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_e;

    // Number of set bits in a 16-key snapshot.
    function automatic logic [4:0] count_ones(input logic [15:0] vec);
        logic [4:0] total;
        total = 5'd0;
        for (int i = 0; i < 16; i++) begin
            total = total + {4'd0, vec[i]};
        end
        return total;
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [3:0] lowest_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [CNT_W-1:0] win_cnt_r;
    logic [1:0]       col_idx_r;
    logic [3:0]       col_r;
    logic [15:0]      snapshot_r;
    logic [15:0]      snap_next_s;
    logic             scan_done_r;
    logic             win_last_s;

    logic [4:0]       ones_s;
    cls_e             cls_kind_s;
    logic [3:0]       cls_key_s;
    logic             same_cls_s;
    logic [3:0]       stab_next_s;
    logic             stable_s;

    state_e           state_r;
    logic [3:0]       stab_cnt_r;
    cls_e             prev_kind_r;
    logic [3:0]       prev_key_r;
    logic [3:0]       key_code_r;
    logic             key_valid_r;
    logic             key_held_r;

    assign COL       = col_r;
    assign KEY_CODE  = key_code_r;
    assign KEY_VALID = key_valid_r;
    assign KEY_HELD  = key_held_r;

    // Two-flop synchronizer for the rows; preset to all-ones (no key) in reset.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= ROW;
            row_sync_r <= row_meta_r;
        end
    end

    // End of the current column window.
    always_comb begin
        win_last_s = (win_cnt_r == CNT_LAST);
    end

    // Window counter, column index and registered one-cold column drive.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            win_cnt_r <= '0;
            col_idx_r <= 2'd0;
            col_r     <= 4'b1110;
        end else if (win_last_s) begin
            win_cnt_r <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= {col_r[2:0], col_r[3]};
        end else begin
            win_cnt_r <= win_cnt_r + CNT_ONE;
            col_idx_r <= col_idx_r;
            col_r     <= col_r;
        end
    end

    // Snapshot with the current column's inverted rows merged in at bits col+4*row.
    always_comb begin
        snap_next_s = snapshot_r;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_idx_r == 2'(c)) begin
                    snap_next_s[4*r+c] = ~row_sync_r[r];
                end else begin
                    snap_next_s[4*r+c] = snapshot_r[4*r+c];
                end
            end
        end
    end

    // Store the column sample at the window end; flag completion of column 3.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            snapshot_r  <= 16'h0000;
            scan_done_r <= 1'b0;
        end else begin
            if (win_last_s) begin
                snapshot_r <= snap_next_s;
            end else begin
                snapshot_r <= snapshot_r;
            end
            scan_done_r <= win_last_s && (col_idx_r == 2'd3);
        end
    end

    // Classify the completed scan and work out the next stability count.
    always_comb begin
        ones_s    = count_ones(snapshot_r);
        cls_key_s = lowest_index(snapshot_r);
        if (ones_s == 5'd0) begin
            cls_kind_s = CLS_NONE;
        end else if (ones_s == 5'd1) begin
            cls_kind_s = CLS_SINGLE;
        end else begin
            cls_kind_s = CLS_MULTI;
        end
        // The key index only distinguishes classifications of the SINGLE kind.
        same_cls_s = (cls_kind_s == prev_kind_r) &&
                     ((cls_kind_s != CLS_SINGLE) || (cls_key_s == prev_key_r));
        if (!same_cls_s) begin
            stab_next_s = 4'd1;
        end else if (stab_cnt_r >= DEB_MAX) begin
            stab_next_s = DEB_MAX;
        end else begin
            stab_next_s = stab_cnt_r + 4'd1;
        end
        stable_s = (stab_next_s == DEB_MAX);
    end

    // Debounce bookkeeping and committed-press FSM with registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            stab_cnt_r  <= 4'd0;
            prev_kind_r <= CLS_NONE;
            prev_key_r  <= 4'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else if (scan_done_r) begin
            stab_cnt_r  <= stab_next_s;
            prev_kind_r <= cls_kind_s;
            prev_key_r  <= cls_key_s;
            case (state_r)
                ST_IDLE: begin
                    if (stable_s && (cls_kind_s == CLS_SINGLE)) begin
                        key_code_r  <= cls_key_s;
                        key_valid_r <= 1'b1;
                        key_held_r  <= 1'b1;
                        state_r     <= ST_PRESSED;
                    end else begin
                        key_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    key_valid_r <= 1'b0;
                    // Rollover and multi-key states are ignored until a full release.
                    if (stable_s && (cls_kind_s == CLS_NONE)) begin
                        key_held_r <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_PRESSED;
                    end
                end
                default: begin
                    key_valid_r <= 1'b0;
                    key_held_r  <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end else begin
            key_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_SCANS=3).
// A keypad model pulls ROW[r] low while COL[c] is low and key r*4+c is closed.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 3;
    localparam int SCAN     = 4 * SCAN_DIV;
    localparam int LAT_MAX  = DEB * SCAN + 2;
    localparam int NS       = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_s;
    logic [3:0]  row_s;
    logic [3:0]  key_code_s;
    logic        key_valid_s;
    logic        key_held_s;
    logic [15:0] keys_r;

    int   cyc = 0;
    int   rel_cyc = 0;
    int   pulse_cnt = 0;
    int   pulse_cyc = 0;
    int   pulse_code = 0;
    int   consec_err = 0;
    logic prev_valid = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    // Scan-level reference model state.
    int   hist[$];
    bit   m_held;
    int   m_code;

    typedef struct {
        int         edge_n;
        logic [3:0] col;
    } col_vec_t;
    col_vec_t col_tab[10];

    // Free-running clock.
    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .COL      (col_s),
        .ROW      (row_s),
        .KEY_CODE (key_code_s),
        .KEY_VALID(key_valid_s),
        .KEY_HELD (key_held_s)
    );

    // Keypad matrix: a closed key shorts its row to the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_s[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (keys_r[4*r+c] && !col_s[c]) row_s[r] = 1'b0;
            end
        end
    end

    // Count rising clock edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (key_valid_s) begin
            pulse_cnt  <= pulse_cnt + 1;
            pulse_cyc  <= cyc;
            pulse_code <= int'(key_code_s);
            if (prev_valid) consec_err <= consec_err + 1;
        end
        prev_valid <= key_valid_s;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_le(input string name, input int act, input int max);
        n_tests++;
        if (act > max) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected at most %0d", name, act, max);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n  = 1'b0;
        keys_r = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic expect_pulse(input string name, input int base, input int limit, input int code);
        int n = 0;
        while (pulse_cnt == base && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pulses"}, pulse_cnt - base, 1);
        check({name, "_code"}, pulse_code, code);
    endtask

    task automatic wait_release(input string name, input int limit);
        int n = 0;
        while (key_held_s && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_held_low"}, int'(key_held_s), 0);
    endtask

    function automatic int classify(input logic [15:0] k);
        if ($countones(k) == 0) return -1;
        if ($countones(k) > 1) return -2;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    // One scan of the reference model: run-length debounce plus press/release rules.
    task automatic model_scan(input logic [15:0] k, output bit exp_valid);
        int cls;
        int run;
        cls = classify(k);
        hist.push_back(cls);
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == cls; i--) run++;
        exp_valid = 1'b0;
        if (run >= DEB) begin
            if (!m_held && cls >= 0) begin
                m_held    = 1'b1;
                m_code    = cls;
                exp_valid = 1'b1;
            end else if (m_held && cls == -1) begin
                m_held = 1'b0;
            end
        end
    endtask

    initial begin
        int          t0;
        int          t1;
        int          base;
        int          exp_pulses;
        bit          ev;
        logic [15:0] pat[NS];

        col_tab[0] = '{1,  4'b1110};
        col_tab[1] = '{7,  4'b1110};
        col_tab[2] = '{8,  4'b1101};
        col_tab[3] = '{15, 4'b1101};
        col_tab[4] = '{16, 4'b1011};
        col_tab[5] = '{23, 4'b1011};
        col_tab[6] = '{24, 4'b0111};
        col_tab[7] = '{31, 4'b0111};
        col_tab[8] = '{32, 4'b1110};
        col_tab[9] = '{40, 4'b1101};

        rst_n  = 1'b0;
        keys_r = 16'h0000;

        // 1. Reset values and column sequencing.
        repeat (3) @(negedge clk);
        check("rst_col", int'(col_s), 4'b1110);
        check("rst_code", int'(key_code_s), 0);
        check("rst_valid", int'(key_valid_s), 0);
        check("rst_held", int'(key_held_s), 0);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        foreach (col_tab[i]) begin
            wait_until(rel_cyc + col_tab[i].edge_n);
            check("col_seq", int'(col_s), int'(col_tab[i].col));
        end

        // 2. Single press of key (2,1) for 300 cycles, then release.
        reset_dut();
        wait_until(rel_cyc + 2 * SCAN);
        t0 = cyc;
        base = pulse_cnt;
        keys_r[9] = 1'b1;
        expect_pulse("press9", base, LAT_MAX + 10, 9);
        check_le("press9_latency", pulse_cyc - t0, LAT_MAX);
        check("press9_held", int'(key_held_s), 1);
        wait_until(t0 + 300);
        check("press9_once", pulse_cnt - base, 1);
        keys_r = 16'h0000;
        t1 = cyc;
        wait_release("release9", LAT_MAX + 10);
        check_le("release9_latency", cyc - t1, LAT_MAX);
        check("release9_no_pulse", pulse_cnt - base, 1);

        // 3. Bounce on key (0,3), then steady hold.
        reset_dut();
        wait_until(rel_cyc + 2 * SCAN);
        t0 = cyc;
        base = pulse_cnt;
        for (int i = 0; i < 12; i++) begin
            keys_r[3] = (i % 2 == 0);
            wait_until(t0 + 10 * (i + 1));
        end
        keys_r[3] = 1'b1;
        check("bounce_no_pulse", pulse_cnt - base, 0);
        expect_pulse("bounce3", base, 150, 3);
        repeat (2 * SCAN) @(negedge clk);
        check("bounce3_once", pulse_cnt - base, 1);
        keys_r = 16'h0000;
        wait_release("bounce3", 150);

        // 4. Keys 0 and 5 together, then key 0 released.
        reset_dut();
        wait_until(rel_cyc + 2 * SCAN);
        t0 = cyc;
        base = pulse_cnt;
        keys_r[0] = 1'b1;
        keys_r[5] = 1'b1;
        wait_until(t0 + 50);
        check("multi_no_pulse", pulse_cnt - base, 0);
        keys_r[0] = 1'b0;
        expect_pulse("multi_to5", base, 150, 5);
        repeat (2 * SCAN) @(negedge clk);
        check("multi_to5_once", pulse_cnt - base, 1);
        keys_r = 16'h0000;
        wait_release("multi_to5", 150);

        // 5. Rollover rejection: 3 held, 12 added, 3 released, full release, 12 alone.
        reset_dut();
        wait_until(rel_cyc + 2 * SCAN);
        base = pulse_cnt;
        keys_r[3] = 1'b1;
        expect_pulse("roll3", base, 150, 3);
        keys_r[12] = 1'b1;
        repeat (4 * SCAN) @(negedge clk);
        check("roll_multi_held", int'(key_held_s), 1);
        check("roll_multi_no_pulse", pulse_cnt - base, 1);
        keys_r[3] = 1'b0;
        repeat (4 * SCAN) @(negedge clk);
        check("roll_12_held", int'(key_held_s), 1);
        check("roll_12_code", int'(key_code_s), 3);
        check("roll_12_no_pulse", pulse_cnt - base, 1);
        keys_r = 16'h0000;
        wait_release("roll", 150);
        keys_r[12] = 1'b1;
        expect_pulse("roll12", base + 1, 150, 12);
        keys_r = 16'h0000;
        wait_release("roll12", 150);

        // 6. Reset mid-press with key 6 held throughout.
        reset_dut();
        wait_until(rel_cyc + 2 * SCAN);
        base = pulse_cnt;
        keys_r[6] = 1'b1;
        expect_pulse("hold6", base, 150, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_held", int'(key_held_s), 0);
        check("midrst_code", int'(key_code_s), 0);
        check("midrst_col", int'(col_s), 4'b1110);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        base    = pulse_cnt;
        expect_pulse("repress6", base, LAT_MAX + 10, 6);
        check_le("repress6_latency", pulse_cyc - rel_cyc, LAT_MAX);
        keys_r = 16'h0000;

        // 7. Random scan-aligned key patterns against the scan-level model.
        begin
            int m = 0;
            while (m < NS) begin
                int          len;
                int          sel;
                int          k1;
                logic [15:0] p;
                len = $urandom_range(1, 5);
                sel = $urandom_range(0, 9);
                k1  = $urandom_range(0, 15);
                p   = 16'h0000;
                if (sel >= 4) p[k1] = 1'b1;
                if (sel >= 8) p[(k1 + 1 + $urandom_range(0, 14)) % 16] = 1'b1;
                for (int j = 0; j < len && m < NS; j++) begin
                    pat[m] = p;
                    m++;
                end
            end
        end
        reset_dut();
        hist.delete();
        m_held     = 1'b0;
        m_code     = 0;
        exp_pulses = 0;
        base       = pulse_cnt;
        for (int m = 0; m <= NS; m++) begin
            wait_until(rel_cyc + m * SCAN);
            keys_r = (m < NS) ? pat[m] : 16'h0000;
            if (m > 0) begin
                wait_until(rel_cyc + m * SCAN + 1);
                model_scan(pat[m-1], ev);
                if (ev) exp_pulses++;
                check("rand_valid", int'(key_valid_s), int'(ev));
                check("rand_held", int'(key_held_s), int'(m_held));
                check("rand_code", int'(key_code_s), m_code);
            end
        end
        check("rand_pulse_count", pulse_cnt - base, exp_pulses);
        check("valid_never_consecutive", consec_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
